// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execute-stage controller: FSM state encoding and instruction/jump types.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package exec_ctrl_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } exec_ctrl_state_t;

  // Resolved control-flow outcome of one executed instruction
  typedef struct packed {
    logic  taken;
    addr_t dest;
  } jump_res_t;

  // Redirect target to present with a flush; zero when no jump was taken
  function automatic addr_t redirect_pc(input jump_res_t j);
    return j.taken ? j.dest : '0;
  endfunction

endpackage

// File: rtl/exec_watchdog.sv
// Counts cycles since start and flags expiry at the CYCLES-th counted cycle.
// Latency: expired is combinational from the count; counting starts the cycle after start.
// Backpressure: none; done disarms the counter, start re-arms it from zero.
module exec_watchdog #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic done,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Arm and clear on start, disarm on done, otherwise advance while armed
  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    if (start) begin
      armed_d = 1'b1;
      cnt_d   = '0;
    end else if (done) begin
      armed_d = 1'b0;
    end else if (armed_q) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign expired = armed_q && (cnt_q == CW'(CYCLES - 1));

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage sequencer: accept one decoded op, pulse execute, await result, offer it to writeback.
// Latency: 5 cycles minimum issue-to-issue; flush pulses in the first HOLD cycle on a taken jump.
// Backpressure: dec_ready only in IDLE; HOLD stalls until wb_ready. EXEC_CTRL_TIMEOUT_EN adds a WAIT abort.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dec_valid,
  output logic        dec_ready,
  output logic        ex_enabled,
  input  logic        ex_completed,
  input  logic        ex_is_jump_chosen,
  input  logic [31:0] ex_jump_dest,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic [31:0] retired_count,
  output logic        timeout
);

  exec_ctrl_state_t state_q, state_d;
  logic             wait_first_q, wait_first_d;
  logic             flush_q, flush_d;
  addr_t            flush_pc_q, flush_pc_d;
  logic [31:0]      retired_count_q, retired_count_d;
  logic             complete;
  logic             wd_expired;
  jump_res_t        jres;

  // The first WAIT cycle still sees the previous op's completion level
  assign complete = (state_q == ST_WAIT) && !wait_first_q && ex_completed;
  assign jres     = '{taken: ex_is_jump_chosen, dest: ex_jump_dest};

`ifdef EXEC_CTRL_TIMEOUT_EN
  logic wd_start, wd_done;
  logic timeout_q, timeout_d;

  assign wd_start = (state_q == ST_ISSUE);
  assign wd_done  = (state_q == ST_WAIT) && (state_d != ST_WAIT);

  exec_watchdog #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .start  (wd_start),
    .done   (wd_done),
    .expired(wd_expired)
  );

  // Sticky abort flag: set when WAIT is left for IDLE, cleared only by reset
  always_comb begin
    timeout_d = timeout_q | ((state_q == ST_WAIT) && (state_d == ST_IDLE));
  end

  // Abort flag register
  always_ff @(posedge clk) begin
    if (!rstn) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end

  assign timeout = timeout_q;
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Next-state: completion takes priority over watchdog expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (dec_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (complete)        state_d = ST_HOLD;
        else if (wd_expired) state_d = ST_IDLE;
      end
      ST_HOLD:  if (wb_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: first-WAIT marker, flush pulse, retire counter
  always_comb begin
    wait_first_d    = (state_q == ST_ISSUE);
    flush_d         = complete && ex_is_jump_chosen;
    flush_pc_d      = complete ? redirect_pc(jres) : '0;
    retired_count_d = retired_count_q;
    if ((state_q == ST_HOLD) && wb_ready) retired_count_d = retired_count_q + 32'd1;
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      wait_first_q    <= 1'b0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      wait_first_q    <= wait_first_d;
      flush_q         <= flush_d;
      flush_pc_q      <= flush_pc_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Outputs decoded from the current state and registered pulses
  always_comb begin
    dec_ready     = (state_q == ST_IDLE);
    ex_enabled    = (state_q == ST_ISSUE);
    wb_valid      = (state_q == ST_HOLD);
    flush         = flush_q;
    flush_pc      = flush_pc_q;
    retired_count = retired_count_q;
  end

endmodule
